// File: rtl/ifid_skid_reg.sv
// IF/ID skid register: 2-entry (main + skid) buffer between fetch and decode with registered in_ready.
// Define IFID_STAT_EN to build the saturating statistics counters; otherwise the stat_* ports read 0.
module ifid_skid_reg #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] NOP_INST = 32'h0000_0013,
  parameter int              CNT_W    = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  in_pc,
  input  logic [XLEN-1:0]  in_inst,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_pc,
  output logic [XLEN-1:0]  out_inst,
  output logic [CNT_W-1:0] stat_accept_cnt,
  output logic [CNT_W-1:0] stat_flush_cnt,
  output logic [CNT_W-1:0] stat_full_cnt
);

  typedef enum logic [1:0] {EMPTY, BUSY, FULL} state_t;

  state_t          state_reg;
  logic [XLEN-1:0] main_pc_reg, main_inst_reg;
  logic [XLEN-1:0] skid_pc_reg, skid_inst_reg;
  logic            accept, drain;

  // in_ready depends only on registered state, so out_ready never reaches it combinationally.
  assign in_ready  = ~reset & (state_reg != FULL);
  assign out_valid = (state_reg != EMPTY);
  assign out_pc    = out_valid ? main_pc_reg   : '0;
  assign out_inst  = out_valid ? main_inst_reg : NOP_INST;
  assign accept    = in_valid & in_ready;
  assign drain     = out_valid & out_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg     <= EMPTY;
      main_pc_reg   <= '0;
      main_inst_reg <= NOP_INST;
      skid_pc_reg   <= '0;
      skid_inst_reg <= NOP_INST;
    end else if (flush) begin
      state_reg <= EMPTY;
    end else begin
      case (state_reg)
        EMPTY: begin
          if (accept) begin
            state_reg     <= BUSY;
            main_pc_reg   <= in_pc;
            main_inst_reg <= in_inst;
          end
        end
        BUSY: begin
          if (accept && drain) begin
            main_pc_reg   <= in_pc;
            main_inst_reg <= in_inst;
          end else if (accept) begin
            state_reg     <= FULL;
            skid_pc_reg   <= in_pc;
            skid_inst_reg <= in_inst;
          end else if (drain) begin
            state_reg <= EMPTY;
          end
        end
        FULL: begin
          if (drain) begin
            state_reg     <= BUSY;
            main_pc_reg   <= skid_pc_reg;
            main_inst_reg <= skid_inst_reg;
          end
        end
        default: state_reg <= EMPTY;
      endcase
    end
  end

`ifdef IFID_STAT_EN
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] accept_cnt_reg, flush_cnt_reg, full_cnt_reg;
  logic [1:0]       flush_drop;
  logic [CNT_W:0]   flush_sum;

  // A main entry drained in the flush cycle was consumed by decode, so it is not a drop.
  always_comb begin
    flush_drop = 2'd0;
    if (out_valid && !drain)  flush_drop = flush_drop + 2'd1;
    if (state_reg == FULL)    flush_drop = flush_drop + 2'd1;
    if (accept)               flush_drop = flush_drop + 2'd1;
  end

  assign flush_sum = {1'b0, flush_cnt_reg} + {{(CNT_W-1){1'b0}}, flush_drop};

  always_ff @(posedge clock) begin
    if (reset) begin
      accept_cnt_reg <= '0;
      flush_cnt_reg  <= '0;
      full_cnt_reg   <= '0;
    end else begin
      if (accept && accept_cnt_reg != '1)
        accept_cnt_reg <= accept_cnt_reg + CNT_ONE;
      if (state_reg == FULL && full_cnt_reg != '1)
        full_cnt_reg <= full_cnt_reg + CNT_ONE;
      if (flush)
        flush_cnt_reg <= flush_sum[CNT_W] ? '1 : flush_sum[CNT_W-1:0];
    end
  end

  assign stat_accept_cnt = accept_cnt_reg;
  assign stat_flush_cnt  = flush_cnt_reg;
  assign stat_full_cnt   = full_cnt_reg;
`else
  assign stat_accept_cnt = '0;
  assign stat_flush_cnt  = '0;
  assign stat_full_cnt   = '0;
`endif

endmodule

// File: tb/tb_ifid_skid_reg.sv
// Self-checking bench for ifid_skid_reg: directed scenarios plus random traffic against a queue model.
module tb_ifid_skid_reg;
  localparam int XLEN  = 32;
  localparam int CNT_W = 32;
  localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

  logic             clock = 1'b0;
  logic             reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [XLEN-1:0]  in_pc, in_inst, out_pc, out_inst;
  logic [CNT_W-1:0] stat_accept_cnt, stat_flush_cnt, stat_full_cnt;

  ifid_skid_reg #(.XLEN(XLEN), .NOP_INST(NOP), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst),
    .stat_accept_cnt(stat_accept_cnt), .stat_flush_cnt(stat_flush_cnt),
    .stat_full_cnt(stat_full_cnt)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: FIFO of {pc, inst} beats, capacity two, plus plain integer counters.
  logic [63:0] q[$];
  longint      m_accept, m_flush, m_full;
  localparam longint CNT_MAX = (64'd1 << CNT_W) - 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic longint sat(input longint v);
    return (v > CNT_MAX) ? CNT_MAX : v;
  endfunction

  // One clock: drive inputs, check outputs mid-cycle, advance the model at the edge.
  task automatic cycle(input logic iv, input logic [31:0] pc, input logic ordy,
                       input logic fl, input logic rst);
    logic        m_in_ready, m_out_valid, acc, drn;
    logic [31:0] inst;
    int          size_before;
    inst      = $urandom;
    reset     = rst;
    flush     = fl;
    in_valid  = iv;
    in_pc     = pc;
    in_inst   = inst;
    out_ready = ordy;
    @(negedge clock);
    m_in_ready  = !rst && (q.size() < 2);
    m_out_valid = (q.size() > 0);
    check("in_ready",  {63'd0, in_ready},  {63'd0, m_in_ready});
    check("out_valid", {63'd0, out_valid}, {63'd0, m_out_valid});
    check("out_pc",    {32'd0, out_pc},    m_out_valid ? {32'd0, q[0][63:32]} : 64'd0);
    check("out_inst",  {32'd0, out_inst},  m_out_valid ? {32'd0, q[0][31:0]}  : {32'd0, NOP});
`ifdef IFID_STAT_EN
    check("stat_accept", {32'd0, stat_accept_cnt}, m_accept);
    check("stat_flush",  {32'd0, stat_flush_cnt},  m_flush);
    check("stat_full",   {32'd0, stat_full_cnt},   m_full);
`else
    check("stat_tied", {stat_accept_cnt, stat_flush_cnt} | {32'd0, stat_full_cnt}, 64'd0);
`endif
    acc = iv && m_in_ready;
    drn = m_out_valid && ordy;
    size_before = q.size();
    @(posedge clock);
    if (rst) begin
      q.delete();
      m_accept = 0; m_flush = 0; m_full = 0;
    end else begin
      if (acc) m_accept = sat(m_accept + 1);
      if (size_before == 2) m_full = sat(m_full + 1);
      if (drn) void'(q.pop_front());
      if (fl) begin
        m_flush = sat(m_flush + q.size() + (acc ? 1 : 0));
        q.delete();
      end else if (acc) begin
        q.push_back({pc, inst});
      end
    end
    #1;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_pc = '0; in_inst = '0;
    m_accept = 0; m_flush = 0; m_full = 0;
    @(posedge clock); @(posedge clock); #1;
    cycle(0, 32'h0, 0, 0, 1);

    // Back-to-back stream at full rate.
    cycle(1, 32'h0, 1, 0, 0);
    cycle(1, 32'h4, 1, 0, 0);
    cycle(1, 32'h8, 1, 0, 0);
    cycle(0, 32'h0, 1, 0, 0);
    cycle(0, 32'h0, 1, 0, 0);

    // Fill to FULL, hold, then drain in order.
    cycle(1, 32'h10, 0, 0, 0);
    cycle(1, 32'h14, 0, 0, 0);
    cycle(1, 32'h18, 0, 0, 0);
    cycle(0, 32'h0, 0, 0, 0);
    cycle(0, 32'h0, 1, 0, 0);
    cycle(0, 32'h0, 1, 0, 0);
    cycle(0, 32'h0, 1, 0, 0);

    // Flush from FULL with an incoming beat.
    cycle(1, 32'h20, 0, 0, 0);
    cycle(1, 32'h24, 0, 0, 0);
    cycle(1, 32'h28, 0, 1, 0);
    cycle(0, 32'h0, 0, 0, 0);

    // Flush from BUSY while the presented beat drains, then a fresh beat.
    cycle(1, 32'h30, 0, 0, 0);
    cycle(0, 32'h0, 1, 1, 0);
    cycle(1, 32'h100, 0, 0, 0);
    cycle(0, 32'h0, 1, 0, 0);
    cycle(0, 32'h0, 0, 0, 0);

    // Flush from BUSY with same-cycle accept and no drain.
    cycle(1, 32'h34, 0, 0, 0);
    cycle(1, 32'h38, 0, 1, 0);
    cycle(0, 32'h0, 0, 0, 0);

    // Reset while FULL, then normal delivery.
    cycle(1, 32'h40, 0, 0, 0);
    cycle(1, 32'h44, 0, 0, 0);
    cycle(1, 32'h48, 1, 0, 1);
    cycle(1, 32'h0, 1, 0, 0);
    cycle(0, 32'h0, 1, 0, 0);
    cycle(0, 32'h0, 1, 0, 0);

    // Random traffic.
    begin
      logic [31:0] pc_r;
      pc_r = 32'h1000;
      for (int i = 0; i < 10000; i++) begin
        logic iv, ordy, fl, rst;
        iv   = ($urandom_range(0, 3) != 0);
        ordy = ($urandom_range(0, 2) != 0);
        fl   = ($urandom_range(0, 31) == 0);
        rst  = ($urandom_range(0, 499) == 0);
        cycle(iv, pc_r, ordy, fl, rst);
        pc_r = pc_r + 32'd4;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
